// File: rtl/alu_result_mux_reg.sv
// Selects one of NUM_IN ALU results and buffers it in a main register plus a skid register.
// Latency: one cycle from accept to out_valid; full throughput with out_ready held high.
// Backpressure: in_ready is the registered inverse of skid-full, so it never depends on out_ready this cycle.
// Optional zero_flag output per entry is enabled by defining ALU_RESULT_MUX_ZERO_FLAG_EN.
module alu_result_mux_reg #(
    parameter int WIDTH  = 24,
    parameter int NUM_IN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN*WIDTH-1:0]    in_bus,
    input  logic [$clog2(NUM_IN)-1:0]  sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err,
    output logic [7:0]                 err_cnt
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
    ,
    output logic                       zero_flag
`endif
);

    localparam int SEL_W = $clog2(NUM_IN);
    // Out-of-range selects only exist when NUM_IN is not a power of two.
    localparam bit HAS_OOR = (NUM_IN < (1 << SEL_W));

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] cap_dat;
    logic             cap_err;

    logic             main_vld;
    logic [WIDTH-1:0] main_dat;
    logic             main_err;
    logic             skid_vld;
    logic [WIDTH-1:0] skid_dat;
    logic             skid_err;

`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
    logic cap_zf;
    logic main_zf;
    logic skid_zf;

    assign cap_zf    = (cap_dat == '0);
    assign zero_flag = main_zf;
`endif

    assign in_ready  = ~skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign sel_err   = main_err;

    assign push = in_valid & ~skid_vld;
    assign pop  = main_vld & out_ready;

    always_comb begin
        cap_dat = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                cap_dat = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign cap_err = HAS_OOR && (int'(sel) >= NUM_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            main_err <= 1'b0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            skid_err <= 1'b0;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
            main_zf  <= 1'b0;
            skid_zf  <= 1'b0;
`endif
        end else if (!main_vld) begin
            // Skid is always empty while main is empty.
            if (push) begin
                main_vld <= 1'b1;
                main_dat <= cap_dat;
                main_err <= cap_err;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
                main_zf  <= cap_zf;
`endif
            end
        end else if (pop) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                main_err <= skid_err;
                skid_vld <= 1'b0;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
                main_zf  <= skid_zf;
`endif
            end else if (push) begin
                main_dat <= cap_dat;
                main_err <= cap_err;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
                main_zf  <= cap_zf;
`endif
            end else begin
                main_vld <= 1'b0;
            end
        end else if (push) begin
            skid_vld <= 1'b1;
            skid_dat <= cap_dat;
            skid_err <= cap_err;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
            skid_zf  <= cap_zf;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (push && cap_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_mux_reg.sv
// Drives a default (NUM_IN=8) and a NUM_IN=7 instance with shared stimulus and compares both
// against a two-deep in-order queue model.
module tb_alu_result_mux_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [191:0] in_bus;
    logic [2:0]   sel;
    logic         in_valid;
    logic         out_ready;

    logic         rdy8, vld8, err8;
    logic [23:0]  dat8;
    logic [7:0]   cnt8;
    logic         rdy7, vld7, err7;
    logic [23:0]  dat7;
    logic [7:0]   cnt7;
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
    logic         zf8, zf7;
`endif

    typedef struct {
        logic [23:0] d8;
        logic        e8;
        logic [23:0] d7;
        logic        e7;
    } ent_t;

    ent_t        q[$];
    int          exp_cnt8, exp_cnt7;
    int          checks, errors;
    logic [23:0] a_val, b_val;

    always #5 clk = ~clk;

    alu_result_mux_reg dut8 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy8), .out_data(dat8),
        .out_valid(vld8), .out_ready(out_ready), .sel_err(err8), .err_cnt(cnt8)
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
        , .zero_flag(zf8)
`endif
    );

    alu_result_mux_reg #(.WIDTH(24), .NUM_IN(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus[167:0]), .sel(sel),
        .in_valid(in_valid), .in_ready(rdy7), .out_data(dat7),
        .out_valid(vld7), .out_ready(out_ready), .sel_err(err7), .err_cnt(cnt7)
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
        , .zero_flag(zf7)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        bit full, any;
        full = (q.size() >= 2);
        any  = (q.size() >= 1);
        chk("rdy8", 32'(rdy8), 32'(!full));
        chk("rdy7", 32'(rdy7), 32'(!full));
        chk("vld8", 32'(vld8), 32'(any));
        chk("vld7", 32'(vld7), 32'(any));
        chk("cnt8", 32'(cnt8), 32'(exp_cnt8));
        chk("cnt7", 32'(cnt7), 32'(exp_cnt7));
        if (any) begin
            chk("dat8", 32'(dat8), 32'(q[0].d8));
            chk("dat7", 32'(dat7), 32'(q[0].d7));
            chk("serr8", 32'(err8), 32'(q[0].e8));
            chk("serr7", 32'(err7), 32'(q[0].e7));
`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
            chk("zf8", 32'(zf8), 32'(q[0].d8 == 24'd0));
            chk("zf7", 32'(zf7), 32'(q[0].d7 == 24'd0));
`endif
        end
    endtask

    // One clock: decide handshakes from the model, take the edge, update the model, compare.
    task automatic step();
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        e.d8 = in_bus[int'(sel)*24 +: 24];
        e.e8 = 1'b0;
        e.e7 = (sel >= 3'd7);
        e.d7 = e.e7 ? 24'd0 : in_bus[int'(sel)*24 +: 24];
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
            if (e.e7 && exp_cnt7 < 255) exp_cnt7++;
        end
        check_outputs();
    endtask

    task automatic rand_bus();
        for (int i = 0; i < 6; i++) in_bus[i*32 +: 32] = $urandom;
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt8 = 0; exp_cnt7 = 0;
        rst_n = 1'b0; in_bus = '0; sel = 3'd0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_vld", 32'(vld8), 32'd0);
        chk("rst_rdy", 32'(rdy8), 32'd1);
        chk("rst_dat", 32'(dat8), 32'd0);
        chk("rst_serr", 32'(err8), 32'd0);
        chk("rst_cnt7", 32'(cnt7), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single push, one cycle latency.
        rand_bus();
        in_bus[2*24 +: 24] = 24'h001234;
        sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("lat_vld", 32'(vld8), 32'd1);
        chk("lat_dat", 32'(dat8), 32'h001234);
        chk("lat_serr", 32'(err8), 32'd0);

        // Out-of-range select on the NUM_IN=7 instance, then saturation.
        rand_bus();
        sel = 3'd7;
        step();
        chk("oor_dat7", 32'(dat7), 32'd0);
        chk("oor_serr7", 32'(err7), 32'd1);
        chk("oor_cnt7", 32'(cnt7), 32'd1);
        for (int i = 0; i < 300; i++) begin
            rand_bus();
            step();
        end
        chk("sat_cnt7", 32'(cnt7), 32'd255);
        chk("sat_cnt8", 32'(cnt8), 32'd0);

        // Backpressure: fill both registers, then drain in order.
        in_valid = 1'b0;
        step(); step();
        out_ready = 1'b0;
        rand_bus(); sel = 3'd1; in_valid = 1'b1; a_val = in_bus[24 +: 24];
        step();
        rand_bus(); sel = 3'd3; b_val = in_bus[72 +: 24];
        step();
        in_valid = 1'b0;
        step();
        chk("bp_rdy", 32'(rdy8), 32'd0);
        chk("bp_headA", 32'(dat8), 32'(a_val));
        out_ready = 1'b1;
        step();
        chk("bp_headB", 32'(dat8), 32'(b_val));
        chk("bp_rdy_up", 32'(rdy8), 32'd1);
        step();
        chk("bp_empty", 32'(vld8), 32'd0);

        // Streaming: one result per cycle, in_ready never drops.
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_bus();
            sel = 3'(i % 6);
            step();
            chk("stream_rdy", 32'(rdy8), 32'd1);
            chk("stream_vld", 32'(vld8), 32'd1);
        end

`ifdef ALU_RESULT_MUX_ZERO_FLAG_EN
        rand_bus(); in_bus[0 +: 24] = 24'd0; sel = 3'd0;
        step();
        chk("zf_zero", 32'(zf8), 32'd1);
        rand_bus(); in_bus[0 +: 24] = 24'h000100;
        step();
        chk("zf_nonzero", 32'(zf8), 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_bus();
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) in_bus[int'(sel)*24 +: 24] = 24'd0;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Reset with both registers full.
        in_valid = 1'b1; out_ready = 1'b0; sel = 3'd7;
        rand_bus(); step();
        rand_bus(); step();
        rand_bus(); step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(vld8), 32'd0);
        chk("mrst_rdy", 32'(rdy8), 32'd1);
        chk("mrst_cnt7", 32'(cnt7), 32'd0);
        chk("mrst_dat", 32'(dat8), 32'd0);
        q.delete();
        exp_cnt7 = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(); step();
        chk("mrst_nostale", 32'(vld8), 32'd0);
        rand_bus(); sel = 3'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
